dyn_branch_predictor: RTL
=========================

// Module: dyn_branch_predictor
// PURPOSE
//  Fetch-stage predictor for the RAT pipeline; second generation of the static BRN/CALL predictor.
//  - Unconditional BRN/CALL: redirects fetch to the decoded target.
//  - Conditional BREQ/BRNE/BRCS/BRCC: predicted by a table of 2-bit saturating counters.
//  - RET: predicted by a return-address stack (RAS).
//  Prediction is combinational in the fetch cycle; the execute stage trains the table.
// PARAMETERS
//  ADDR_W     10  program-counter / branch-target width
//  IDX_W      4   counter-table index width; table holds 2**IDX_W entries
//  RAS_DEPTH  4   return-address-stack entries (power of 2, >= 2)
// PORTS
//  CLK                in   1       clock; all state updates on rising edge
//  RST                in   1       asynchronous, active-high reset
//  BP_OPCODE_HI_5     in   5       fetched opcode [6:2]
//  BP_OPCODE_LO_2     in   2       fetched opcode [1:0]
//  BP_CURR_ADDR       in   ADDR_W  PC of fetched instruction
//  BP_BRN_ADDR        in   ADDR_W  immediate target decoded from instruction
//  BP_NOP_CLR         in   1       fetch slot is a bubble/flushed; suppress prediction and RAS action
//  BP_STALL           in   1       fetch held; suppress RAS push/pop (prediction still driven)
//  BP_RES_VALID       in   1       execute reports a resolved conditional branch
//  BP_RES_IDX         in   IDX_W   table index that was used when that branch was predicted
//  BP_RES_TAKEN       in   1       actual outcome
//  BP_PC_LD           out  1       load PC with BP_PRED_ADDR this cycle
//  BP_PC_CNT_MUX_SEL  out  1       PC mux selects BP_PRED_ADDR (equals BP_PC_LD)
//  BP_PRED_ADDR       out  ADDR_W  predicted target (BP_BRN_ADDR, or RAS top for RET)
//  BP_COND_BRN_TAKEN  out  1       predicted direction of a conditional branch; piped to execute
//  BP_PRED_IDX        out  IDX_W   index used this cycle; piped to execute, returned as BP_RES_IDX
// BEHAVIOUR
//  - Opcodes {HI,LO}:
//    - BRN 0010000, CALL 0010001: taken; CALL also pushes BP_CURR_ADDR+1 (mod 2**ADDR_W).
//    - BREQ 0010010, BRNE 0010011, BRCS 0010100, BRCC 0010101: conditional.
//    - RET 0110010: pops the RAS.
//    - Any other opcode: all outputs 0 except BP_PRED_IDX.
//  - Index: idx = BP_CURR_ADDR[IDX_W-1:0] (see CONFIGURATION).
//  - Counter FSM per entry (states SNT=00, WNT=01, WT=10, ST=11):
//    - Taken: move up one state, saturating at ST. Not-taken: move down one, saturating at SNT.
//    - Prediction = counter MSB.
//  - Conditional branch: BP_COND_BRN_TAKEN = MSB; BP_PC_LD = MSB; BP_PRED_ADDR = BP_BRN_ADDR.
//  - RET: if RAS non-empty, BP_PC_LD=1 and BP_PRED_ADDR = top.
//    If empty, BP_PC_LD=0 (no prediction) and the pop is ignored.
//  - RAS: circular buffer, pointer plus count (count saturates at RAS_DEPTH).
//    - Push when full overwrites the oldest entry.
//    - Push/pop only if !BP_NOP_CLR && !BP_STALL.
//    - No repair on mispredict; the wrong path can corrupt it.
//  - Training: when BP_RES_VALID, counter[BP_RES_IDX] updates on the edge.
//    It is independent of BP_STALL and BP_NOP_CLR.
//  - Same-cycle read and train of one index: the read sees the pre-update value (no bypass).
//  - BP_NOP_CLR=1: BP_PC_LD, BP_PC_CNT_MUX_SEL, BP_COND_BRN_TAKEN, BP_PRED_ADDR = 0.
//  - Latency: prediction is 0-cycle combinational; counter/RAS/history effects are visible next cycle.
//  - Reset (async, any time, incl. mid-RAS-op):
//    - All counters = WNT; RAS pointer and count = 0; history = 0.
//    - While RST=1, all outputs = 0.
// CONFIGURATION
//  BP_GSHARE_EN defined:
//    - Adds an IDX_W-bit global history register.
//    - On each BP_RES_VALID it shifts left and takes in BP_RES_TAKEN at bit 0.
//    - idx = BP_CURR_ADDR[IDX_W-1:0] ^ history.
//  BP_GSHARE_EN undefined: no history register; idx = PC low bits only.
//  Training always uses BP_RES_IDX, so the resolve path is identical in both builds.
// STRUCTURE
//  - Package bp_pkg:
//    - opcode constants OP_BRN, OP_CALL, OP_BREQ, OP_BRNE, OP_BRCS, OP_BRCC, OP_RET;
//    - typedef enum logic [1:0] bp_ctr_t {SNT, WNT, WT, ST};
//    - ctr_next(bp_ctr_t, taken) saturating function.
//  - Sub-module bp_ras (params ADDR_W, RAS_DEPTH; ports push, pop, push_data, top, empty).
//  - The counter table and control logic stay in the top level.
// TESTING
//  1 Reset, BREQ at PC 0x005, target 0x040 -> BP_COND_BRN_TAKEN=0, BP_PC_LD=0, BP_PRED_IDX=5.
//  2 Train idx 5 taken x2, refetch BREQ@0x005 -> taken, PC_LD=1, PRED_ADDR=0x040;
//    train not-taken x4 -> SNT, sticks at SNT.
//  3 CALL@0x010 then RET -> RET predicts 0x011 with PC_LD=1;
//    second RET (empty) -> PC_LD=0.
//  4 Five CALLs @0x100..0x104 with RAS_DEPTH=4, five RETs ->
//    0x105, 0x104, 0x103, 0x102, then no prediction.
//  5 BP_NOP_CLR=1 with BRN or CALL -> all controls 0, RAS count unchanged;
//    BP_STALL=1 with CALL -> no push.
//  6 BP_GSHARE_EN: 3 taken resolves, then fetch PC 0x000 -> BP_PRED_IDX=0x7;
//    RST mid-sequence -> history 0, all counters WNT.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor: opcode constants,
// the 2-bit saturating counter type and its update function.
package bp_pkg;

   localparam int unsigned OP_W = 7;

   localparam logic [OP_W-1:0] OP_BRN  = 7'b0010000;
   localparam logic [OP_W-1:0] OP_CALL = 7'b0010001;
   localparam logic [OP_W-1:0] OP_BREQ = 7'b0010010;
   localparam logic [OP_W-1:0] OP_BRNE = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BRCS = 7'b0010100;
   localparam logic [OP_W-1:0] OP_BRCC = 7'b0010101;
   localparam logic [OP_W-1:0] OP_RET  = 7'b0110010;

   // Strongly/weakly not-taken, weakly/strongly taken; MSB is the prediction.
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   // Move one state toward the actual outcome, saturating at both ends.
   function automatic bp_ctr_t ctr_next(input bp_ctr_t c, input logic taken);
      bp_ctr_t n;
      case (c)
         SNT:     n = taken ? WNT : SNT;
         WNT:     n = taken ? WT  : SNT;
         WT:      n = taken ? ST  : WNT;
         ST:      n = taken ? ST  : WT;
         default: n = WNT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bp_ras.sv
// Return-address stack: circular buffer with a write pointer and a saturating
// occupancy count. A push into a full stack overwrites the oldest entry; a pop
// of an empty stack is ignored.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push, pop   stack operations (never both in one cycle from the top level)
//   push_data   return address to store
//   top         most recently pushed entry (valid when !empty)
//   empty       no entries held
module bp_ras #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              empty
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
   logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  top_ptr;

   // ptr_q is the next free slot; the top lives one below it (wrapping).
   assign top_ptr = ptr_q - PTR_W'(1);
   assign top     = mem_q[top_ptr];
   assign empty   = (cnt_q == '0);

   // Next-state for storage, pointer and count.
   always_comb begin
      mem_d = mem_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[ptr_q] = push_data;
         ptr_d        = ptr_q + PTR_W'(1);
         if (cnt_q != CNT_W'(RAS_DEPTH)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         ptr_d = top_ptr;
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dyn_branch_predictor.sv
// Fetch-stage dynamic branch predictor. BRN/CALL always redirect to the decoded
// target, conditional branches use a table of 2-bit saturating counters and RET
// uses a return-address stack. Prediction is combinational; execute trains the
// table through the resolve port.
// Optional feature: define BP_GSHARE_EN to XOR a global outcome history into
// the table index used at fetch.
// Ports:
//   CLK, RST                          clock, asynchronous active-high reset
//   BP_OPCODE_HI_5/LO_2               fetched opcode bits [6:2] / [1:0]
//   BP_CURR_ADDR, BP_BRN_ADDR         fetch PC, decoded immediate target
//   BP_NOP_CLR, BP_STALL              bubble slot / fetch hold
//   BP_RES_VALID/IDX/TAKEN            resolved conditional branch from execute
//   BP_PC_LD, BP_PC_CNT_MUX_SEL       redirect fetch to BP_PRED_ADDR
//   BP_PRED_ADDR                      predicted target
//   BP_COND_BRN_TAKEN, BP_PRED_IDX    direction and index piped to execute
module dyn_branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned IDX_W     = 4,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [4:0]        BP_OPCODE_HI_5,
   input  logic [1:0]        BP_OPCODE_LO_2,
   input  logic [ADDR_W-1:0] BP_CURR_ADDR,
   input  logic [ADDR_W-1:0] BP_BRN_ADDR,
   input  logic              BP_NOP_CLR,
   input  logic              BP_STALL,
   input  logic              BP_RES_VALID,
   input  logic [IDX_W-1:0]  BP_RES_IDX,
   input  logic              BP_RES_TAKEN,
   output logic              BP_PC_LD,
   output logic              BP_PC_CNT_MUX_SEL,
   output logic [ADDR_W-1:0] BP_PRED_ADDR,
   output logic              BP_COND_BRN_TAKEN,
   output logic [IDX_W-1:0]  BP_PRED_IDX
);

   localparam int unsigned TBL_N = 2 ** IDX_W;

   logic [OP_W-1:0]   op;
   logic [IDX_W-1:0]  idx;
   bp_ctr_t           rd_ctr;
   bp_ctr_t           ctr_q [TBL_N];
   bp_ctr_t           ctr_d [TBL_N];
   logic              ras_ok;
   logic              ras_push;
   logic              ras_pop;
   logic              ras_empty;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] ras_push_data;

   assign op            = {BP_OPCODE_HI_5, BP_OPCODE_LO_2};
   assign ras_push_data = BP_CURR_ADDR + ADDR_W'(1);
   assign ras_ok        = !RST && !BP_NOP_CLR && !BP_STALL;

`ifdef BP_GSHARE_EN
   logic [IDX_W-1:0] hist_q, hist_d;

   // Global history of resolved outcomes, newest at bit 0.
   always_comb begin
      hist_d = hist_q;
      if (BP_RES_VALID) begin
         hist_d = {hist_q[IDX_W-2:0], BP_RES_TAKEN};
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign idx = BP_CURR_ADDR[IDX_W-1:0] ^ hist_q;
`else
   assign idx = BP_CURR_ADDR[IDX_W-1:0];
`endif

   // Read port sees the registered value only; same-cycle training is not bypassed.
   assign rd_ctr = ctr_q[idx];

   // Opcode decode and prediction outputs.
   always_comb begin
      BP_PC_LD          = 1'b0;
      BP_PRED_ADDR      = '0;
      BP_COND_BRN_TAKEN = 1'b0;
      ras_push          = 1'b0;
      ras_pop           = 1'b0;
      if (!RST && !BP_NOP_CLR) begin
         case (op)
            OP_BRN: begin
               BP_PC_LD     = 1'b1;
               BP_PRED_ADDR = BP_BRN_ADDR;
            end
            OP_CALL: begin
               BP_PC_LD     = 1'b1;
               BP_PRED_ADDR = BP_BRN_ADDR;
               ras_push     = ras_ok;
            end
            OP_BREQ, OP_BRNE, OP_BRCS, OP_BRCC: begin
               BP_COND_BRN_TAKEN = rd_ctr[1];
               BP_PC_LD          = rd_ctr[1];
               BP_PRED_ADDR      = BP_BRN_ADDR;
            end
            OP_RET: begin
               // Empty stack: no prediction, and the pop is dropped.
               if (!ras_empty) begin
                  BP_PC_LD     = 1'b1;
                  BP_PRED_ADDR = ras_top;
                  ras_pop      = ras_ok;
               end
            end
            default: ;
         endcase
      end
      BP_PC_CNT_MUX_SEL = BP_PC_LD;
      BP_PRED_IDX       = RST ? '0 : idx;
   end

   // Counter training from execute, independent of fetch stall/bubble.
   always_comb begin
      ctr_d = ctr_q;
      if (BP_RES_VALID) begin
         ctr_d[BP_RES_IDX] = ctr_next(ctr_q[BP_RES_IDX], BP_RES_TAKEN);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ctr_q <= '{default: WNT};
      end else begin
         ctr_q <= ctr_d;
      end
   end

   bp_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (CLK),
      .rst       (RST),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (ras_push_data),
      .top       (ras_top),
      .empty     (ras_empty)
   );

endmodule
